// File: rtl/spi_frame_master.sv
// SPI master: sends SPI_WORDS words of SPI_BITS bits per chip-select frame, all four CPOL/CPHA modes.
// Optional macro SPI_LSB_FIRST_EN shifts and assembles each word LSB first (default MSB first).
module spi_frame_master #(
    parameter int unsigned SPI_BITS   = 8,
    parameter int unsigned SPI_WORDS  = 2,
    parameter int unsigned SPI_DIV    = 3,
    parameter int unsigned CS_SETUP   = 2,
    parameter int unsigned GAP_CYCLES = 12,
    parameter int unsigned CS_HOLD    = 2
) (
    input  logic                            clk_12mhz,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            abort,
    input  logic [1:0]                      mode,
    input  logic [SPI_BITS*SPI_WORDS-1:0]   tx_frame,
    output logic [SPI_BITS*SPI_WORDS-1:0]   rx_frame,
    output logic                            busy,
    output logic                            done,
    output logic                            spi_clk,
    output logic                            spi_mosi,
    input  logic                            spi_miso,
    output logic                            spi_cs
);
    localparam int unsigned FRAME_W = SPI_BITS * SPI_WORDS;
    localparam int unsigned IDX_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int unsigned BIT_W   = $clog2(SPI_BITS + 1);
    localparam int unsigned WORD_W  = $clog2(SPI_WORDS + 1);
    localparam int unsigned MAX_A   = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned MAX_B   = (GAP_CYCLES > 2 * SPI_DIV) ? GAP_CYCLES : 2 * SPI_DIV;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_GAP, S_HOLD, S_DONE} state_t;

    state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [BIT_W-1:0]     r_bit, w_bit_nxt;
    logic [WORD_W-1:0]    r_word, w_word_nxt;
    logic [1:0]           r_mode, w_mode_nxt;
    logic [FRAME_W-1:0]   r_tx, w_tx_nxt;
    logic [FRAME_W-1:0]   r_rx, w_rx_nxt;
    logic [FRAME_W-1:0]   w_rx_frame_nxt;
    logic                 w_cs_nxt, w_sck_nxt, w_mosi_nxt, w_busy_nxt, w_done_nxt;
    logic                 w_last_bit, w_last_word;
    logic [IDX_W-1:0]     w_cur_idx, w_nxt_idx;

    // Frame bit position of transmitted bit number bit_n within word
    function automatic logic [IDX_W-1:0] f_idx(input logic [WORD_W-1:0] word,
                                               input logic [BIT_W-1:0]  bit_n);
        int unsigned pos;
`ifdef SPI_LSB_FIRST_EN
        pos = 32'(bit_n);
`else
        pos = SPI_BITS - 1 - 32'(bit_n);
`endif
        return IDX_W'(32'(word) * SPI_BITS + pos);
    endfunction

    assign w_last_bit  = (r_bit == BIT_W'(SPI_BITS - 1));
    assign w_last_word = (r_word == WORD_W'(SPI_WORDS - 1));
    assign w_cur_idx   = f_idx(r_word, r_bit);
    assign w_nxt_idx   = w_last_bit ? f_idx(r_word + WORD_W'(1), '0)
                                    : f_idx(r_word, r_bit + BIT_W'(1));

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_bit_nxt      = r_bit;
        w_word_nxt     = r_word;
        w_mode_nxt     = r_mode;
        w_tx_nxt       = r_tx;
        w_rx_nxt       = r_rx;
        w_rx_frame_nxt = rx_frame;
        w_cs_nxt       = spi_cs;
        w_sck_nxt      = spi_clk;
        w_mosi_nxt     = spi_mosi;
        w_busy_nxt     = busy;
        w_done_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cs_nxt   = 1'b1;
                w_sck_nxt  = r_mode[1];
                w_busy_nxt = 1'b0;
                if (start && !abort) begin
                    w_state_nxt = S_SETUP;
                    w_mode_nxt  = mode;
                    w_tx_nxt    = tx_frame;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_word_nxt  = '0;
                    w_cs_nxt    = 1'b0;
                    w_sck_nxt   = mode[1];
                    w_busy_nxt  = 1'b1;
                    w_mosi_nxt  = tx_frame[f_idx('0, '0)];
                end
            end
            S_SETUP: begin
                if (r_cnt == CNT_W'(CS_SETUP - 1)) begin
                    w_state_nxt = S_SHIFT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(SPI_DIV - 1)) begin
                    // leading edge: CPHA=1 launches, CPHA=0 captures
                    w_sck_nxt = ~r_mode[1];
                    if (r_mode[0]) w_mosi_nxt = r_tx[w_cur_idx];
                    else           w_rx_nxt[w_cur_idx] = spi_miso;
                end else if (r_cnt == CNT_W'(2 * SPI_DIV - 1)) begin
                    w_sck_nxt = r_mode[1];
                    w_cnt_nxt = '0;
                    if (r_mode[0])                        w_rx_nxt[w_cur_idx] = spi_miso;
                    else if (!(w_last_bit && w_last_word)) w_mosi_nxt = r_tx[w_nxt_idx];
                    if (!w_last_bit) begin
                        w_bit_nxt = r_bit + BIT_W'(1);
                    end else begin
                        w_bit_nxt = '0;
                        if (w_last_word) begin
                            w_state_nxt = S_HOLD;
                        end else begin
                            w_word_nxt  = r_word + WORD_W'(1);
                            w_state_nxt = (GAP_CYCLES == 0) ? S_SHIFT : S_GAP;
                        end
                    end
                end
            end
            S_GAP: begin
                if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    w_state_nxt = S_SHIFT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (r_cnt == CNT_W'(CS_HOLD - 1)) begin
                    w_state_nxt    = S_DONE;
                    w_cnt_nxt      = '0;
                    w_cs_nxt       = 1'b1;
                    w_done_nxt     = 1'b1;
                    w_rx_frame_nxt = r_rx;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // abort overrides everything outside IDLE; received data is discarded
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt    = S_IDLE;
            w_cs_nxt       = 1'b1;
            w_sck_nxt      = r_mode[1];
            w_busy_nxt     = 1'b0;
            w_done_nxt     = 1'b0;
            w_rx_frame_nxt = rx_frame;
        end
    end

    always_ff @(posedge clk_12mhz or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_word   <= '0;
            r_mode   <= '0;
            r_tx     <= '0;
            r_rx     <= '0;
            rx_frame <= '0;
            spi_cs   <= 1'b1;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bit    <= w_bit_nxt;
            r_word   <= w_word_nxt;
            r_mode   <= w_mode_nxt;
            r_tx     <= w_tx_nxt;
            r_rx     <= w_rx_nxt;
            rx_frame <= w_rx_frame_nxt;
            spi_cs   <= w_cs_nxt;
            spi_clk  <= w_sck_nxt;
            spi_mosi <= w_mosi_nxt;
            busy     <= w_busy_nxt;
            done     <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master: scoreboard of expected rx frames plus a bus monitor and SPI slave.
module tb_spi_frame_master;
    localparam int unsigned BITS  = 8;
    localparam int unsigned WORDS = 2;
    localparam int unsigned DIV   = 3;
    localparam int unsigned SETUP = 2;
    localparam int unsigned GAP   = 12;
    localparam int unsigned HOLD  = 2;
    localparam int unsigned FW    = BITS * WORDS;
    localparam int unsigned IW    = $clog2(FW);
    localparam int unsigned FRAME_LEN = SETUP + WORDS * BITS * 2 * DIV + (WORDS - 1) * GAP + HOLD;

    logic          clk_12mhz = 1'b0;
    logic          rst, start, abort;
    logic [1:0]    mode;
    logic [FW-1:0] tx_frame, rx_frame;
    logic          busy, done, spi_clk, spi_mosi, spi_miso, spi_cs;

    int n_checks = 0;
    int n_fail   = 0;
    int miso_sel = 0;

    logic [FW-1:0] exp_rx_q[$];

    spi_frame_master #(
        .SPI_BITS(BITS), .SPI_WORDS(WORDS), .SPI_DIV(DIV),
        .CS_SETUP(SETUP), .GAP_CYCLES(GAP), .CS_HOLD(HOLD)
    ) dut (
        .clk_12mhz(clk_12mhz), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .tx_frame(tx_frame), .rx_frame(rx_frame), .busy(busy), .done(done),
        .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs(spi_cs)
    );

    always #5 clk_12mhz = ~clk_12mhz;

    // SPI slave: launches the next bit of slave_frame on every rising SCK (mode 1 leading edge)
    logic [FW-1:0] slave_frame = '0;
    logic          slave_bit = 1'b0;
    int            slave_pos = 0;
    always @(posedge spi_clk or posedge spi_cs) begin
        if (spi_cs) begin
            slave_pos = 0;
        end else if (slave_pos < int'(FW)) begin
`ifdef SPI_LSB_FIRST_EN
            slave_bit = slave_frame[IW'(slave_pos)];
`else
            slave_bit = slave_frame[IW'((slave_pos / BITS) * BITS + BITS - 1 - (slave_pos % BITS))];
`endif
            slave_pos++;
        end
    end

    assign spi_miso = (miso_sel == 0) ? spi_mosi : (miso_sel == 1) ? 1'b1 : slave_bit;

    // bus monitor: frame length, SCK edges, MOSI at the slave's sampling edge
    logic prev_cs = 1'b1, prev_clk = 1'b0, prev_mosi = 1'b0;
    logic mosi_q[$];
    int   cyc = 0, cs_low_cycles = 0, edge_cnt = 0, bad_mosi = 0, edge_a_t = 0, edge_b_t = 0;
    always @(negedge clk_12mhz) begin
        cyc++;
        if (!spi_cs && prev_cs) begin
            cs_low_cycles = 0;
            edge_cnt = 0;
            bad_mosi = 0;
            mosi_q.delete();
        end
        if (!spi_cs) cs_low_cycles++;
        if (!spi_cs && !prev_cs && (spi_clk !== prev_clk)) begin
            edge_cnt++;
            if (edge_cnt == int'(2 * BITS))     edge_a_t = cyc;
            if (edge_cnt == int'(2 * BITS + 1)) edge_b_t = cyc;
            if ((spi_clk !== mode[1]) != mode[0]) mosi_q.push_back(spi_mosi);
        end
        if (!spi_cs && !prev_cs && (spi_mosi !== prev_mosi) && !(prev_clk && !spi_clk)) bad_mosi++;
        prev_cs   = spi_cs;
        prev_clk  = spi_clk;
        prev_mosi = spi_mosi;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_12mhz);
    endtask

    function automatic logic [FW-1:0] mosi_frame();
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < mosi_q.size() && i < int'(FW); i++) begin
`ifdef SPI_LSB_FIRST_EN
            f[IW'((i / BITS) * BITS + (i % BITS))] = mosi_q[i];
`else
            f[IW'((i / BITS) * BITS + BITS - 1 - (i % BITS))] = mosi_q[i];
`endif
        end
        return f;
    endfunction

    function automatic logic [7:0] first_byte_seq();
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < 8 && i < mosi_q.size(); i++) b = {b[6:0], mosi_q[i]};
        return b;
    endfunction

    task automatic run_frame(input logic [1:0] m, input logic [FW-1:0] tx, input logic [FW-1:0] exp_rx);
        logic          got;
        logic [FW-1:0] exp_v;
        got = 1'b0;
        mode = m;
        tx_frame = tx;
        start = 1'b1;
        exp_rx_q.push_back(exp_rx);
        tick(1);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("cs_low_setup", 32'(spi_cs), 32'd0);
        chk("sck_idle_setup", 32'(spi_clk), 32'(m[1]));
        for (int i = 0; i < 1000 && !got; i++) begin
            if (i == 20) begin start = 1'b1; tx_frame = ~tx; end
            if (i == 21) begin start = 1'b0; tx_frame = tx; end
            tick(1);
            if (done) got = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
        if (got) begin
            exp_v = exp_rx_q.pop_front();
            chk("rx_frame", 32'(rx_frame), 32'(exp_v));
            chk("busy_in_done", 32'(busy), 32'd1);
            chk("cs_high_done", 32'(spi_cs), 32'd1);
        end
        chk("cs_low_len", 32'(cs_low_cycles), 32'(FRAME_LEN));
        chk("sck_edges", 32'(edge_cnt), 32'(WORDS * BITS * 2));
        chk("gap_spacing", 32'(edge_b_t - edge_a_t), 32'(GAP + DIV));
        chk("mosi_seq", 32'(mosi_frame()), 32'(tx));
        tick(1);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_falls", 32'(busy), 32'd0);
        chk("sck_idle_after", 32'(spi_clk), 32'(m[1]));
    endtask

    initial begin
        int n_done;
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'b00; tx_frame = '0;
        tick(3);
        chk("rst_cs", 32'(spi_cs), 32'd1);
        chk("rst_sck", 32'(spi_clk), 32'd0);
        chk("rst_mosi", 32'(spi_mosi), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rx", 32'(rx_frame), 32'd0);
        rst = 1'b0;
        tick(2);

        // mode 0 loopback
        miso_sel = 0;
        run_frame(2'b00, 16'h1101, 16'h1101);
`ifdef SPI_LSB_FIRST_EN
        chk("word0_bit_order", 32'(first_byte_seq()), 32'h80);
`else
        chk("word0_bit_order", 32'(first_byte_seq()), 32'h01);
`endif

        // mode 3, MISO tied high
        miso_sel = 1;
        run_frame(2'b11, 16'hA55A, 16'hFFFF);
        chk("mosi_on_falling", 32'(bad_mosi), 32'd0);

        // mode 1 against the bench slave
        miso_sel = 2;
        slave_frame = 16'hC33C;
        run_frame(2'b01, 16'h00FF, 16'hC33C);

        // abort on the 40th SHIFT cycle
        miso_sel = 0;
        mode = 2'b00;
        tx_frame = 16'h1234;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(41);
        chk("sck_active_pre_abort", 32'(spi_clk), 32'd1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_cs", 32'(spi_cs), 32'd1);
        chk("abort_sck", 32'(spi_clk), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) n_done++;
            tick(1);
        end
        chk("abort_no_done", 32'(n_done), 32'd0);
        chk("abort_rx_kept", 32'(rx_frame), 32'hC33C);

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 32'd0);
        chk("idle_abort_cs", 32'(spi_cs), 32'd1);
        tick(1);

        run_frame(2'b00, 16'h1234, 16'h1234);

        // reset mid-frame in mode 2 (SCK idles high)
        mode = 2'b10;
        tx_frame = 16'h5A5A;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(26);
        chk("sck_high_pre_rst", 32'(spi_clk), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_cs", 32'(spi_cs), 32'd1);
        chk("mid_rst_sck", 32'(spi_clk), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rx", 32'(rx_frame), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(1);
        run_frame(2'b00, 16'h1101, 16'h1101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
